// File: rtl/uart_line_echo.sv
// uart_line_echo: circular-FIFO echo between UART RX and TX byte cores, either per byte
// or per line (flushed on CR/LF or idle timeout and followed by CR LF).
module uart_line_echo #(
  parameter int DATA_W = 8,
  parameter int BUF_DEPTH = 64,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter logic [DATA_W-1:0] CR_CHAR = 8'h0D,
  parameter logic [DATA_W-1:0] LF_CHAR = 8'h0A
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              line_mode,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] test_data,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       drop_count,
  output logic [15:0]       line_count
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {S_COLLECT, S_SEND_BODY, S_SEND_CR, S_SEND_LF} state_t;
  state_t            state_q;
  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d, snap_q;
  logic [TW-1:0]     to_q, to_d;
  logic              mode_q;
  logic              mode_eff, is_term, store, pop, push, drop, to_act, expire, flush;
  // Outside S_COLLECT the mode latched at flush decides whether terminators are dropped.
  always_comb begin
    mode_eff = (state_q == S_COLLECT) ? line_mode : mode_q;
    is_term  = (rx_data == CR_CHAR) || (rx_data == LF_CHAR);
    store    = !(mode_eff && is_term);
    pop      = (state_q == S_SEND_BODY) && tx_valid && tx_ready;
    push     = rx_valid && store && ((count_q < CW'(BUF_DEPTH)) || pop);
    drop     = rx_valid && store && !push;
    count_d  = count_q + CW'(push) - CW'(pop);
    to_act   = (state_q == S_COLLECT) && line_mode && (count_q != '0);
    expire   = to_act && !rx_valid && (to_q == TW'(TIMEOUT_CYC - 1));
    to_d     = (!to_act || rx_valid || expire) ? '0 : to_q + 1'b1;
    flush    = (state_q == S_COLLECT) && (count_q != '0) &&
               (!line_mode || (rx_valid && is_term) || expire);
  end
  assign busy = state_q != S_COLLECT;
  always_ff @(posedge sys_clk) if (push) mem_q[wr_ptr_q] <= rx_data;
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_COLLECT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      snap_q     <= '0;
      to_q       <= '0;
      mode_q     <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      test_data  <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      line_count <= '0;
    end else begin
      overflow <= drop;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (rx_valid) test_data <= rx_data;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      to_q    <= to_d;
      case (state_q)
        S_COLLECT: if (flush) begin
          snap_q   <= count_q;
          mode_q   <= line_mode;
          tx_data  <= mem_q[rd_ptr_q];
          tx_valid <= 1'b1;
          state_q  <= S_SEND_BODY;
        end
        S_SEND_BODY: if (pop) begin
          snap_q   <= snap_q - 1'b1;
          tx_valid <= (snap_q == CW'(1)) && mode_q;
          if (snap_q == CW'(1)) state_q <= mode_q ? S_SEND_CR : S_COLLECT;
          if (snap_q == CW'(1) && mode_q) tx_data <= CR_CHAR;
        end else if (!tx_valid) begin
          tx_data  <= mem_q[rd_ptr_q];
          tx_valid <= 1'b1;
        end
        S_SEND_CR: if (tx_valid && tx_ready) begin
          tx_data <= LF_CHAR;
          state_q <= S_SEND_LF;
        end
        S_SEND_LF: if (tx_valid && tx_ready) begin
          tx_valid   <= 1'b0;
          line_count <= line_count + 16'd1;
          state_q    <= S_COLLECT;
        end
        default: state_q <= S_COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_line_echo.sv
// tb_uart_line_echo: vector table, multi-cycle corner sequences and random lines
// checked against a queue model of the expected TX byte stream.
`timescale 1ns/1ps
module tb_uart_line_echo;
  localparam int DEPTH = 4;
  localparam int TMO = 100;
  logic clk = 1'b0, rst = 1'b1, line_mode = 1'b0, rx_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] tx_data, test_data;
  logic tx_valid, busy, overflow;
  logic [15:0] drop_count, line_count, lc;
  int n_chk = 0, n_fail = 0, ovf_cycles = 0, rdy_mode = 0;
  int o0, fed, k, n;
  logic [7:0] b;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] mid[4];
  logic stall_q = 1'b0;
  logic [7:0] stall_d = 8'h00;
  typedef struct {
    logic mode; int nrx; logic [47:0] rx; int nexp; logic [47:0] ex; int dl;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  uart_line_echo #(.BUF_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .sys_clk(clk), .sys_rst(rst), .line_mode(line_mode), .rx_valid(rx_valid),
    .rx_data(rx_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .test_data(test_data), .busy(busy), .overflow(overflow),
    .drop_count(drop_count), .line_count(line_count));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) stall_q <= 1'b0;
    else begin
      if (stall_q) begin
        chk("tx_hold_valid", 32'(tx_valid), 32'd1);
        chk("tx_hold_data", 32'(tx_data), 32'(stall_d));
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (overflow) ovf_cycles <= ovf_cycles + 1;
      stall_q <= tx_valid && !tx_ready;
      stall_d <= tx_data;
    end
  end

  task automatic step();
    @(posedge clk); #1;
    if (rdy_mode == 1) tx_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) tx_ready = !tx_ready;
  endtask

  task automatic send(input logic [7:0] v);
    rx_data = v; rx_valid = 1'b1; step(); rx_valid = 1'b0;
  endtask

  task automatic drain(input int cnt, input string name);
    int w = 0;
    while (w < 400 && !(got.size() >= cnt && !busy && !tx_valid)) begin step(); w++; end
    chk({name, "_done"}, 32'(w < 400), 32'd1);
    repeat (4) step();
  endtask

  task automatic cmp_q(input string name);
    chk({name, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_b%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
    got.delete(); exp_q.delete();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", 50000);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1, 48'h410000000000, 1, 48'h410000000000, 0};
    tbl[1] = '{1'b1, 3, 48'h48690D000000, 4, 48'h48690D0A0000, 1};
    tbl[2] = '{1'b1, 1, 48'h0A0000000000, 0, 48'h000000000000, 0};
    tbl[3] = '{1'b0, 2, 48'h0D0A00000000, 2, 48'h0D0A00000000, 0};
    tbl[4] = '{1'b1, 4, 48'h6162630A0000, 5, 48'h6162630D0A00, 1};
    tbl[5] = '{1'b1, 3, 48'h7A0D0D000000, 3, 48'h7A0D0A000000, 1};
    mid = '{8'h31, 8'h0D, 8'h32, 8'h33};
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_lines", 32'(line_count), 0);
    chk("rst_test_data", 32'(test_data), 0);
    @(posedge clk); #1 rst = 1'b0;
    tx_ready = 1'b1;
    step();
    send(8'h41);
    @(negedge clk);
    chk("lat_n1_valid", 32'(tx_valid), 0);
    step();
    @(negedge clk);
    chk("lat_n2_valid", 32'(tx_valid), 1);
    chk("lat_n2_data", 32'(tx_data), 32'h41);
    chk("lat_n2_busy", 32'(busy), 1);
    drain(1, "lat");
    exp_q.push_back(8'h41);
    cmp_q("lat");
    chk("lat_lines", 32'(line_count), 0);
    for (int v = 0; v < 6; v++) begin
      lc = line_count; line_mode = tbl[v].mode; step();
      for (int i = 0; i < tbl[v].nrx; i++) send(tbl[v].rx[47-8*i -: 8]);
      for (int i = 0; i < tbl[v].nexp; i++) exp_q.push_back(tbl[v].ex[47-8*i -: 8]);
      drain(tbl[v].nexp, $sformatf("vec%0d", v));
      cmp_q($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_lines", v), 32'(line_count - lc), 32'(tbl[v].dl));
      chk($sformatf("vec%0d_test_data", v), 32'(test_data), 32'(tbl[v].rx[47-8*(tbl[v].nrx-1) -: 8]));
    end
    lc = line_count; line_mode = 1'b1; step();
    send(8'h78);
    repeat (99) step();
    @(negedge clk);
    chk("tmo_early_valid", 32'(tx_valid), 0);
    step();
    @(negedge clk);
    chk("tmo_valid", 32'(tx_valid), 1);
    chk("tmo_data", 32'(tx_data), 32'h78);
    drain(3, "tmo");
    exp_q = '{8'h78, 8'h0D, 8'h0A};
    cmp_q("tmo");
    chk("tmo_lines", 32'(line_count - lc), 1);
    tx_ready = 1'b0; step();
    o0 = ovf_cycles;
    for (int i = 0; i < 6; i++) send(8'(8'h41 + i));
    repeat (2) step();
    chk("ovf_pulses", 32'(ovf_cycles - o0), 2);
    chk("ovf_drop_count", 32'(drop_count), 2);
    send(8'h0D);
    repeat (5) step();
    chk("ovf_stall_busy", 32'(busy), 1);
    chk("ovf_stall_none", 32'(got.size()), 0);
    lc = line_count; tx_ready = 1'b1;
    drain(6, "ovf");
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    cmp_q("ovf");
    chk("ovf_lines", 32'(line_count - lc), 1);
    lc = line_count; rdy_mode = 2; step();
    send(8'h61); send(8'h62); send(8'h0D);
    fed = 0; k = 0;
    while (k < 200 && !(got.size() >= 4 && !busy)) begin
      if (fed < 4 && got.size() >= 1) begin
        chk("mid_feed_busy", 32'(busy), 1);
        rx_data = mid[fed]; rx_valid = 1'b1; fed++;
      end
      step(); rx_valid = 1'b0; k++;
    end
    chk("mid_done", 32'(k < 200), 1);
    chk("mid_fed", 32'(fed), 4);
    exp_q = '{8'h61, 8'h62, 8'h0D, 8'h0A};
    cmp_q("mid");
    chk("mid_lines", 32'(line_count - lc), 1);
    rdy_mode = 0; tx_ready = 1'b1;
    repeat (50) step();
    chk("mid_hold", 32'(got.size()), 0);
    drain(5, "mid2");
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};
    cmp_q("mid2");
    chk("mid2_lines", 32'(line_count - lc), 2);
    tx_ready = 1'b0; step();
    send(8'h70); send(8'h71); send(8'h0D);
    repeat (3) step();
    chk("rmid_busy", 32'(busy), 1);
    chk("rmid_valid", 32'(tx_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("rmid_rst_valid", 32'(tx_valid), 0);
    chk("rmid_rst_busy", 32'(busy), 0);
    chk("rmid_rst_lines", 32'(line_count), 0);
    chk("rmid_rst_drop", 32'(drop_count), 0);
    chk("rmid_rst_test_data", 32'(test_data), 0);
    step();
    rst = 1'b0; got.delete(); tx_ready = 1'b1; step();
    send(8'h6F); send(8'h6B); send(8'h0A);
    drain(4, "rpost");
    exp_q = '{8'h6F, 8'h6B, 8'h0D, 8'h0A};
    cmp_q("rpost");
    chk("rpost_lines", 32'(line_count), 1);
    rdy_mode = 1;
    for (int it = 0; it < 40; it++) begin
      lc = line_count;
      line_mode = 1'($urandom_range(0, 1)); step();
      if (!line_mode) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
          b = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom);
          send(b); exp_q.push_back(b);
        end
      end else begin
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) begin
          do b = 8'($urandom); while (b == 8'h0D || b == 8'h0A);
          send(b); exp_q.push_back(b);
          repeat ($urandom_range(0, 3)) step();
        end
        send($urandom_range(0, 1) ? 8'h0D : 8'h0A);
        if (n > 0) begin exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); end
      end
      drain(exp_q.size(), $sformatf("rnd%0d", it));
      cmp_q($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_lines", it), 32'(line_count - lc), 32'(line_mode && n > 0));
    end
    chk("rnd_drop", 32'(drop_count), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_line_echo.md
Name: uart_line_echo

Overview:
- Parametrised successor to the string-echo test block. It sits between a UART RX byte core and a UART TX byte core.
- Received bytes are buffered in a circular FIFO and echoed back. There are two modes:
  - Byte mode: immediate per-byte echo.
  - Line mode: buffer until a terminator or idle timeout, then send the line followed by CR LF.
- Adds overflow accounting, timeout flush and a line counter, none of which the earlier echo block had.

Parameters:
- DATA_W, 8: byte width of rx/tx data.
- BUF_DEPTH, 64: FIFO depth in bytes; must be a power of 2, ≥ 4.
- TIMEOUT_CYC, 1_000_000: sys_clk cycles of rx inactivity that flush a partial line (line mode only); must be ≥ 1.
- CR_CHAR, 8'h0D: carriage-return code, used as a terminator and appended.
- LF_CHAR, 8'h0A: line-feed code, used as a terminator and appended.

Ports:
- sys_clk  in  1  system clock; single clock domain.
- sys_rst  in  1  asynchronous, active-high reset.
- line_mode  in  1  0 = byte echo, 1 = line echo; sampled only in S_COLLECT.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new received byte.
- rx_data  in  DATA_W  received byte.
- tx_data  out  DATA_W  byte to the TX core; held stable while tx_valid=1 and tx_ready=0.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  TX core accepts; a transfer occurs when tx_valid and tx_ready are both high.
- test_data  out  DATA_W  last byte seen on rx_valid, including dropped bytes and terminators.
- busy  out  1  FSM is not in S_COLLECT.
- overflow  out  1  one-cycle pulse when a byte is dropped because the FIFO is full.
- drop_count  out  16  number of dropped bytes; saturates at 16'hFFFF.
- line_count  out  16  number of completed line-mode flushes; wraps at 16'hFFFF.

Behaviour:
- Reset (async assert, sync-released use): every output is 0; wr_ptr = rd_ptr = 0, count = 0, state S_COLLECT, timeout counter 0. Reset mid-transmission abandons the byte and clears the FIFO.
- FIFO:
  - Pointers are log2(BUF_DEPTH) bits wide and wrap naturally; count is log2(BUF_DEPTH)+1 bits.
  - Write condition: rx_valid && store && (count < BUF_DEPTH || pop_this_cycle).
  - A push and a pop in the same cycle leave count unchanged; a full FIFO with a simultaneous pop accepts the write.
  - Dropped byte: overflow=1 for one cycle, drop_count +1 (saturating).
  - store = 1, except in line mode when rx_data is CR_CHAR or LF_CHAR (terminators are never stored in line mode).
  - In byte mode terminators are stored and echoed like any other byte.
- Pop: happens on a tx transfer in S_SEND_BODY. The next byte is registered into tx_data the following cycle, so there is one bubble cycle per byte.
- FSM:
  - S_COLLECT:
    - Byte mode: if count > 0, latch snap_len = count and go to S_SEND_BODY.
    - Line mode: if a terminator is received and count > 0, or timeout expires and count > 0, latch snap_len = count (count excludes the terminator) and go to S_SEND_BODY.
    - Line mode, terminator received with count = 0: no action (empty lines are not echoed).
  - S_SEND_BODY:
    - Present FIFO bytes; decrement snap_len per transfer.
    - When it reaches 0: go to S_SEND_CR in line mode (mode latched at entry), otherwise S_COLLECT.
    - Bytes arriving during sending are stored but are not part of the snapshot.
  - S_SEND_CR: tx_data = CR_CHAR; on transfer go to S_SEND_LF.
  - S_SEND_LF: tx_data = LF_CHAR; on transfer line_count +1 and go to S_COLLECT.
  - Terminators received outside S_COLLECT are discarded (not stored, no flush).
- Timeout:
  - Counter is active only in S_COLLECT, line mode, count > 0.
  - It clears on any rx_valid.
  - It expires when it reaches TIMEOUT_CYC - 1, then clears.
- Latency (byte mode, tx_ready=1): rx_valid in cycle N → FIFO write at end of N → FSM leaves S_COLLECT at end of N+1 → tx_valid=1 with the byte in N+2.
- tx_valid drops in the cycle after the final transfer unless another byte is being presented.

Test Plan:
- Byte mode, tx_ready=1, rx "A" (8'h41) in cycle 10 → tx_valid=1, tx_data=8'h41 in cycle 12; no CR/LF; line_count stays 0.
- Line mode, rx "H","i",8'h0D → tx sequence 8'h48, 8'h69, 8'h0D, 8'h0A; line_count = 1; the 8'h0D is not duplicated.
- Line mode, TIMEOUT_CYC=100, rx "x" then silence → flush starts 100 cycles after the "x" strobe; tx 8'h78, 8'h0D, 8'h0A.
- tx_ready=0, BUF_DEPTH=4, push 6 bytes in line mode → first 4 stored; 2 overflow pulses; drop_count = 2; after CR, the line echoes 4 bytes.
- Line mode, tx_ready toggling 1/0 with 3 new bytes arriving mid-line → the first line is sent intact; the new bytes remain with count = 3; the single CR/LF follows the first line only.
- Assert sys_rst during S_SEND_BODY → tx_valid=0 and busy=0 immediately; counters 0; the next line echoes correctly.
